// File: rtl/sim_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// FSM state encoding, STATUS bit positions and the baud reload helper.
package sim_uart_tx_pkg;

  // Word offsets as seen on addr[3:2]
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam logic [1:0] UART_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // A divisor of zero behaves as one cycle per bit.
  function automatic logic [15:0] reload_of(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/sim_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; a push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sim_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and the serialising FSM driving txd.
module sim_uart_tx
  import sim_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        ren,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        txd,
  output logic        irq
);

  tx_state_t   state;
  logic [15:0] baud_div;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        ie;
  logic        ovf;

  logic [1:0]  reg_sel;
  logic        push_req;
  logic        push_drop;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        busy;
  logic        bit_done;
  logic        unused_bits;

  assign reg_sel     = addr[3:2];
  assign busy        = (state != ST_IDLE);
  assign bit_done    = (baud_cnt == 16'd0);
  assign push_req    = wen & (reg_sel == UART_TXDATA) & wstrb[0];
  // The FSM pops either from IDLE or at the end of a stop bit, never mid-frame.
  assign fifo_pop    = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
  assign push_drop   = push_req & fifo_full & ~fifo_pop;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], wstrb[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= DEFAULT_DIV;
      ie       <= 1'b0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wen && reg_sel == UART_BAUDDIV) begin
        if (wstrb[0]) baud_div[7:0]  <= wdata[7:0];
        if (wstrb[1]) baud_div[15:8] <= wdata[15:8];
      end
      if (wen && reg_sel == UART_CTRL && wstrb[0]) ie <= wdata[0];
      if (push_drop)
        ovf <= 1'b1;
      else if (wen && reg_sel == UART_STATUS && wstrb[0] && wdata[STAT_OVF])
        ovf <= 1'b0;
      irq <= ie & fifo_empty & ~busy;
    end
  end

  // txd is updated on the same edge as the state so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      txd      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state    <= ST_START;
            shift    <= fifo_dout;
            baud_cnt <= reload_of(baud_div);
            txd      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state    <= ST_DATA;
            bit_cnt  <= 3'd0;
            baud_cnt <= reload_of(baud_div);
            txd      <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= reload_of(baud_div);
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= reload_of(baud_div);
            if (!fifo_empty) begin
              state <= ST_START;
              shift <= fifo_dout;
              txd   <= 1'b0;
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (ren) begin
      case (reg_sel)
        UART_STATUS: begin
          rdata[STAT_FULL]  = fifo_full;
          rdata[STAT_EMPTY] = fifo_empty;
          rdata[STAT_BUSY]  = busy;
          rdata[STAT_OVF]   = ovf;
        end
        UART_BAUDDIV: rdata[15:0] = baud_div;
        UART_CTRL:    rdata[0]    = ie;
        default:      rdata       = 32'd0;
      endcase
    end
  end

endmodule
